ffo_req_scheduler: RTL and testbench

- Downstream consumer of the nBitFFO priority encoder.
- Accumulates N request bits into a pending vector and feeds that vector to nBitFFO.
- Issues one registered grant (index of the highest pending bit) per cycle over a valid/ready handshake, then clears the granted bit.
- Sits between request sources and a single shared resource.

---
 rtl/ffo_req_scheduler_pkg.sv | 18 +
 rtl/ffo_req_scheduler_if.sv | 31 +++
 rtl/ffo_req_scheduler_nbitffo.sv | 27 ++
 rtl/ffo_req_scheduler.sv | 130 +++++++++++++
 tb/tb_ffo_req_scheduler.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/ffo_req_scheduler_pkg.sv
// ----------------------------------------------------------------------------
// ffo_sched_pkg
//   Shared types and defaults for the ffo_req_scheduler block.
//   - sched_state_t : scheduler FSM state encoding
//   - N_DEF / CW_DEF: default request-line count and grant-counter width
// ----------------------------------------------------------------------------
package ffo_sched_pkg;

  localparam int N_DEF  = 8;
  localparam int CW_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    STALL = 2'd2
  } sched_state_t;

endpackage

// File: rtl/ffo_req_scheduler_if.sv
// ----------------------------------------------------------------------------
// ffo_req_scheduler_if
//   Request and grant handshakes of the scheduler.
//   master : request source / grant consumer side
//   slave  : scheduler side
//   Signals: req_valid, req_bits[N], req_ready, grant_valid,
//            grant_idx[$clog2(N)], grant_ready
// ----------------------------------------------------------------------------
interface ffo_req_scheduler_if #(
  parameter int N = ffo_sched_pkg::N_DEF
);
  localparam int IW = $clog2(N);

  logic          req_valid;
  logic [N-1:0]  req_bits;
  logic          req_ready;
  logic          grant_valid;
  logic [IW-1:0] grant_idx;
  logic          grant_ready;

  modport master (
    output req_valid, req_bits, grant_ready,
    input  req_ready, grant_valid, grant_idx
  );

  modport slave (
    input  req_valid, req_bits, grant_ready,
    output req_ready, grant_valid, grant_idx
  );

endinterface

// File: rtl/ffo_req_scheduler_nbitffo.sv
// ----------------------------------------------------------------------------
// nBitFFO
//   Combinational priority encoder: finds the highest set bit of d_i.
//   d_i [N]  : input vector
//   v_o      : any bit of d_i set
//   i_o [IW] : index of the highest set bit (0 when v_o is low)
// ----------------------------------------------------------------------------
module nBitFFO #(
  parameter int N = 8
) (
  input  logic [N-1:0]         d_i,
  output logic                 v_o,
  output logic [$clog2(N)-1:0] i_o
);
  localparam int IW = $clog2(N);

  // Ascending scan: the last match, i.e. the highest set bit, wins.
  always_comb begin
    i_o = '0;
    for (int i = 0; i < N; i++) begin
      if (d_i[i]) i_o = IW'(i);
    end
  end

  assign v_o = |d_i;

endmodule

// File: rtl/ffo_req_scheduler.sv
// ----------------------------------------------------------------------------
// ffo_req_scheduler
//   Merges incoming request bits into a pending vector and issues one
//   registered grant per cycle for the highest pending bit, clearing that
//   bit as the grant is loaded.
//
//   clk, rst_n   : clock, asynchronous active-low reset
//   bus (slave)  : request handshake in, grant handshake out
//   flush        : synchronous clear of pending vector and grant slot
//   pending [N]  : current pending register
//   busy         : FSM is not IDLE
//   grant_count  : saturating count of completed grant handshakes
//
//   state | meaning
//   IDLE  | nothing pending, no grant held
//   ISSUE | grant being loaded or handed off each cycle
//   STALL | grant held by consumer backpressure
// ----------------------------------------------------------------------------
module ffo_req_scheduler
  import ffo_sched_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int CW = CW_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  ffo_req_scheduler_if.slave  bus,
  input  logic                flush,
  output logic [N-1:0]        pending,
  output logic                busy,
  output logic [CW-1:0]       grant_count
);
  localparam int IW = $clog2(N);

  if ((N < 4) || ((N & (N - 1)) != 0)) begin : g_bad_n
    $fatal(1, "ffo_req_scheduler: N must be a power of 2 and >= 4");
  end

  sched_state_t  state_q, state_d;
  logic [N-1:0]  pending_q, pending_d;
  logic          grant_valid_q, grant_valid_d;
  logic [IW-1:0] grant_idx_q, grant_idx_d;
  logic [CW-1:0] grant_count_q, grant_count_d;

  logic          ffo_v;
  logic [IW-1:0] ffo_i;
  logic          accept, slot_free, load, handshake;

  nBitFFO #(.N(N)) u_ffo (
    .d_i (pending_q),
    .v_o (ffo_v),
    .i_o (ffo_i)
  );

  assign accept    = bus.req_valid && !flush;
  assign slot_free = !grant_valid_q || bus.grant_ready;
  assign load      = slot_free && ffo_v && !flush;
  assign handshake = grant_valid_q && bus.grant_ready;

  // Clear of the granted bit is applied before the merge, so a request for
  // the same bit arriving in the load cycle keeps it pending.
  always_comb begin
    pending_d = pending_q;
    if (load) pending_d[ffo_i] = 1'b0;
    if (accept) pending_d = pending_d | bus.req_bits;
    if (flush) pending_d = '0;
  end

  always_comb begin
    grant_valid_d = grant_valid_q;
    grant_idx_d   = grant_idx_q;
    if (flush) begin
      grant_valid_d = 1'b0;
    end else if (load) begin
      grant_valid_d = 1'b1;
      grant_idx_d   = ffo_i;
    end else if (slot_free) begin
      grant_valid_d = 1'b0;
    end
  end

  // A handshake completing in a flush cycle still counts.
  always_comb begin
    grant_count_d = grant_count_q;
    if (handshake && (grant_count_q != {CW{1'b1}})) begin
      grant_count_d = grant_count_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (ffo_v) state_d = ISSUE;
        ISSUE: begin
          if (grant_valid_q && !bus.grant_ready) state_d = STALL;
          else if (!ffo_v)                       state_d = IDLE;
        end
        STALL:   if (bus.grant_ready) state_d = ISSUE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      pending_q     <= '0;
      grant_valid_q <= 1'b0;
      grant_idx_q   <= '0;
      grant_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      grant_valid_q <= grant_valid_d;
      grant_idx_q   <= grant_idx_d;
      grant_count_q <= grant_count_d;
    end
  end

  assign bus.req_ready   = !flush;
  assign bus.grant_valid = grant_valid_q;
  assign bus.grant_idx   = grant_idx_q;
  assign pending         = pending_q;
  assign busy            = (state_q != IDLE);
  assign grant_count     = grant_count_q;

endmodule

// File: tb/tb_ffo_req_scheduler.sv
// ----------------------------------------------------------------------------
// tb_ffo_req_scheduler
//   Directed bench for ffo_req_scheduler: a per-cycle vector table for the
//   main N=8/CW=16 instance, plus hand sequences for asynchronous reset and
//   grant counter saturation on a CW=4 instance.
// ----------------------------------------------------------------------------
module tb_ffo_req_scheduler;
  import ffo_sched_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush, flush_s;
  logic [7:0]  pending, pending_s;
  logic        busy, busy_s;
  logic [15:0] grant_count;
  logic [3:0]  grant_count_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ffo_req_scheduler_if #(.N(8)) bus ();
  ffo_req_scheduler_if #(.N(8)) bus_s ();

  ffo_req_scheduler #(.N(8), .CW(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus.slave),
    .flush       (flush),
    .pending     (pending),
    .busy        (busy),
    .grant_count (grant_count)
  );

  ffo_req_scheduler #(.N(8), .CW(4)) dut_s (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus_s.slave),
    .flush       (flush_s),
    .pending     (pending_s),
    .busy        (busy_s),
    .grant_count (grant_count_s)
  );

  typedef struct {
    logic         rv;
    logic [7:0]   rb;
    logic         gr;
    logic         fl;
    logic         gv;
    logic [2:0]   gi;
    logic [7:0]   pend;
    logic         bsy;
    logic [15:0]  cnt;
    sched_state_t st;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rv, logic [7:0] rb, logic gr, logic fl,
                              logic gv, logic [2:0] gi, logic [7:0] pend,
                              logic bsy, logic [15:0] cnt, sched_state_t st);
    vec_t v;
    v.rv = rv; v.rb = rb; v.gr = gr; v.fl = fl;
    v.gv = gv; v.gi = gi; v.pend = pend; v.bsy = bsy; v.cnt = cnt; v.st = st;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  initial begin
    // Row k: inputs driven during cycle k; expected = registered state in cycle k.
    //            rv  rb     gr  fl    gv  gi  pend   bsy cnt  state
    // burst A4, free-flowing consumer
    vecs.push_back(mk(1, 8'hA4, 1, 0,  0, 0, 8'h00, 0, 0,  IDLE));   // 0
    vecs.push_back(mk(0, 8'h00, 1, 0,  0, 0, 8'hA4, 0, 0,  IDLE));   // 1
    vecs.push_back(mk(0, 8'h00, 1, 0,  1, 7, 8'h24, 1, 0,  ISSUE));  // 2
    vecs.push_back(mk(0, 8'h00, 1, 0,  1, 5, 8'h04, 1, 1,  ISSUE));  // 3
    vecs.push_back(mk(0, 8'h00, 1, 0,  1, 2, 8'h00, 1, 2,  ISSUE));  // 4
    vecs.push_back(mk(0, 8'h00, 1, 0,  0, 0, 8'h00, 0, 3,  IDLE));   // 5
    // burst A4 with backpressure, merge 41 while stalled
    vecs.push_back(mk(1, 8'hA4, 0, 0,  0, 0, 8'h00, 0, 3,  IDLE));   // 6
    vecs.push_back(mk(0, 8'h00, 0, 0,  0, 0, 8'hA4, 0, 3,  IDLE));   // 7
    vecs.push_back(mk(0, 8'h00, 0, 0,  1, 7, 8'h24, 1, 3,  ISSUE));  // 8
    vecs.push_back(mk(1, 8'h41, 0, 0,  1, 7, 8'h24, 1, 3,  STALL));  // 9
    vecs.push_back(mk(0, 8'h00, 0, 0,  1, 7, 8'h65, 1, 3,  STALL));  // 10
    vecs.push_back(mk(0, 8'h00, 1, 0,  1, 7, 8'h65, 1, 3,  STALL));  // 11
    vecs.push_back(mk(0, 8'h00, 1, 0,  1, 6, 8'h25, 1, 4,  ISSUE));  // 12
    vecs.push_back(mk(0, 8'h00, 1, 0,  1, 5, 8'h05, 1, 5,  ISSUE));  // 13
    vecs.push_back(mk(0, 8'h00, 1, 0,  1, 2, 8'h01, 1, 6,  ISSUE));  // 14
    vecs.push_back(mk(0, 8'h00, 1, 0,  1, 0, 8'h00, 1, 7,  ISSUE));  // 15
    // set wins over clear on bit 5
    vecs.push_back(mk(1, 8'h24, 1, 0,  0, 0, 8'h00, 0, 8,  IDLE));   // 16
    vecs.push_back(mk(1, 8'h20, 1, 0,  0, 0, 8'h24, 0, 8,  IDLE));   // 17
    vecs.push_back(mk(0, 8'h00, 1, 0,  1, 5, 8'h24, 1, 8,  ISSUE));  // 18
    vecs.push_back(mk(0, 8'h00, 1, 0,  1, 5, 8'h04, 1, 9,  ISSUE));  // 19
    vecs.push_back(mk(0, 8'h00, 1, 0,  1, 2, 8'h00, 1, 10, ISSUE));  // 20
    vecs.push_back(mk(0, 8'h00, 1, 0,  0, 0, 8'h00, 0, 11, IDLE));   // 21
    // flush while stalled, requests in flush cycle ignored
    vecs.push_back(mk(1, 8'h81, 0, 0,  0, 0, 8'h00, 0, 11, IDLE));   // 22
    vecs.push_back(mk(0, 8'h00, 0, 0,  0, 0, 8'h81, 0, 11, IDLE));   // 23
    vecs.push_back(mk(0, 8'h00, 0, 0,  1, 7, 8'h01, 1, 11, ISSUE));  // 24
    vecs.push_back(mk(1, 8'hFF, 0, 1,  1, 7, 8'h01, 1, 11, STALL));  // 25
    vecs.push_back(mk(0, 8'h00, 0, 0,  0, 0, 8'h00, 0, 11, IDLE));   // 26
    // handshake in a flush cycle still counts
    vecs.push_back(mk(1, 8'h10, 1, 0,  0, 0, 8'h00, 0, 11, IDLE));   // 27
    vecs.push_back(mk(0, 8'h00, 1, 0,  0, 0, 8'h10, 0, 11, IDLE));   // 28
    vecs.push_back(mk(0, 8'h00, 1, 1,  1, 4, 8'h00, 1, 11, ISSUE));  // 29
    vecs.push_back(mk(0, 8'h00, 1, 0,  0, 0, 8'h00, 0, 12, IDLE));   // 30

    bus.req_valid = 1'b0; bus.req_bits = '0; bus.grant_ready = 1'b0; flush = 1'b0;
    bus_s.req_valid = 1'b0; bus_s.req_bits = '0; bus_s.grant_ready = 1'b0; flush_s = 1'b0;

    // reset state before any clock edge
    #2;
    chk("rst gv", 32'(bus.grant_valid), 32'd0);
    chk("rst pend", 32'(pending), 32'd0);
    chk("rst cnt", 32'(grant_count), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst cnt_s", 32'(grant_count_s), 32'd0);

    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < vecs.size(); k++) begin
      @(negedge clk);
      bus.req_valid   = vecs[k].rv;
      bus.req_bits    = vecs[k].rb;
      bus.grant_ready = vecs[k].gr;
      flush           = vecs[k].fl;
      #1;
      chk($sformatf("r%0d gv", k), 32'(bus.grant_valid), 32'(vecs[k].gv));
      if (vecs[k].gv)
        chk($sformatf("r%0d gi", k), 32'(bus.grant_idx), 32'(vecs[k].gi));
      chk($sformatf("r%0d pend", k), 32'(pending), 32'(vecs[k].pend));
      chk($sformatf("r%0d busy", k), 32'(busy), 32'(vecs[k].bsy));
      chk($sformatf("r%0d cnt", k), 32'(grant_count), 32'(vecs[k].cnt));
      chk($sformatf("r%0d state", k), 32'(dut.state_q), 32'(vecs[k].st));
      chk($sformatf("r%0d rdy", k), 32'(bus.req_ready), 32'(!vecs[k].fl));
    end

    // asynchronous reset mid-operation with a held grant
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_bits = 8'hFF; bus.grant_ready = 1'b0; flush = 1'b0;
    @(negedge clk);
    bus.req_valid = 1'b0; bus.req_bits = 8'h00;
    @(negedge clk);
    #1;
    chk("pre-rst gv", 32'(bus.grant_valid), 32'd1);
    chk("pre-rst pend", 32'(pending), 32'h7F);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst gv", 32'(bus.grant_valid), 32'd0);
    chk("arst pend", 32'(pending), 32'd0);
    chk("arst cnt", 32'(grant_count), 32'd0);
    chk("arst busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // saturation on the CW=4 instance: handshakes start completing at the
    // third edge, so row j has seen max(j-2,0) handshakes, capped at 15
    for (int j = 0; j < 25; j++) begin
      @(negedge clk);
      bus_s.req_valid   = 1'b1;
      bus_s.req_bits    = 8'hFF;
      bus_s.grant_ready = 1'b1;
      #1;
      chk($sformatf("sat j%0d cnt", j), 32'(grant_count_s),
          (j < 2) ? 32'd0 : ((j - 2 > 15) ? 32'd15 : 32'(j - 2)));
    end
    bus_s.req_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("sat final cnt", 32'(grant_count_s), 32'd15);
    chk("main idle gv", 32'(bus.grant_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
